load_unit: RTL and testbench

//  Read-side memory access unit for the multi-cycle core (counterpart of the store path).

---
 rtl/load_unit_pkg.sv | 29 ++
 rtl/load_extract.sv | 30 +++
 rtl/load_unit.sv | 129 ++++++++++++
 tb/tb_load_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// Shared load-path definitions: funct3 load encodings, load-unit FSM states and alignment check.
package load_unit_pkg;

  typedef enum logic [2:0] {
    OpLb  = 3'b000,
    OpLh  = 3'b001,
    OpLw  = 3'b010,
    OpLbu = 3'b100,
    OpLhu = 3'b101
  } load_op_e;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  // Illegal funct3 encodings are reported through the misaligned path as well.
  function automatic logic load_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    logic bad;
    case (funct3)
      OpLb, OpLbu: bad = 1'b0;
      OpLh, OpLhu: bad = lane[0];
      OpLw:        bad = (lane != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the byte/half/word addressed by lane out of a memory word and extends it per funct3.
module load_extract
  import load_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        lane_i,
  input  logic [2:0]        funct3_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[8*lane_i +: 8];
    half_sel = word_i[16*lane_i[1] +: 16];
    data_o   = '0;
    case (funct3_i)
      OpLb:    data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      OpLbu:   data_o = {{(DATA_W-8){1'b0}}, byte_sel};
      OpLh:    data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
      OpLhu:   data_o = {{(DATA_W-16){1'b0}}, half_sel};
      OpLw:    data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Multi-cycle load unit: one aligned word read per request, extended result held for writeback.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_misaligned,
  output logic              rsp_timeout,
  output logic              busy
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              mis_q, mis_d;
  logic              to_q, to_d;
  logic [DATA_W-1:0] ext_data;

  load_extract #(
    .DATA_W(DATA_W)
  ) u_extract (
    .word_i  (mem_rd_data),
    .lane_i  (lane_q),
    .funct3_i(funct3_q),
    .data_o  (ext_data)
  );

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    funct3_d = funct3_q;
    waddr_d  = waddr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    mis_d    = mis_q;
    to_d     = to_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          lane_d   = req_addr[1:0];
          funct3_d = req_funct3;
          waddr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          if (load_misaligned(req_funct3, req_addr[1:0])) begin
            mis_d   = 1'b1;
            data_d  = '0;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // Data arriving on the expiry cycle takes priority over the timeout.
        if (mem_rd_valid) begin
          data_d  = ext_data;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          to_d    = 1'b1;
          data_d  = '0;
          state_d = StResp;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        mis_d   = 1'b0;
        to_d    = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      lane_q   <= '0;
      funct3_q <= '0;
      waddr_q  <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      mis_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      funct3_q <= funct3_d;
      waddr_q  <= waddr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      mis_q    <= mis_d;
      to_q     <= to_d;
    end
  end

  assign req_ready      = (state_q == StIdle);
  assign busy           = (state_q != StIdle);
  assign mem_rd_en      = (state_q == StIssue);
  assign mem_addr       = waddr_q;
  assign rsp_valid      = (state_q == StResp);
  assign rsp_data       = data_q;
  assign rsp_misaligned = mis_q;
  assign rsp_timeout    = to_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit with a small latency-programmable memory model.
module tb_load_unit;
  import load_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_misaligned;
  logic        rsp_timeout;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:63];
  int          mem_lat  = 1;
  bit          mem_mute = 1'b0;
  int          mem_cd   = 0;
  logic [31:0] pend_addr;

  always #5 clk = ~clk;

  load_unit #(
    .DATA_W        (32),
    .ADDR_W        (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_funct3    (req_funct3),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_data   (mem_rd_data),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_misaligned(rsp_misaligned),
    .rsp_timeout   (rsp_timeout),
    .busy          (busy)
  );

  // Memory answers mem_lat cycles after the strobe cycle, with a one-cycle valid pulse.
  initial begin
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    pend_addr    = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rd_valid = 1'b0;
      if (mem_cd > 0) begin
        mem_cd--;
        if (mem_cd == 0 && !mem_mute) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = mem[pend_addr[7:2]];
        end
      end
      if (mem_rd_en) begin
        mem_cd    = mem_lat;
        pend_addr = mem_addr;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request and checks the response against hand-computed expectations.
  task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] exp_data, input logic exp_mis, input logic exp_to,
                          input int exp_lat, input int exp_strobes);
    int          lat;
    int          strobes;
    logic [31:0] seen_addr;
    logic [31:0] d;
    logic        mis;
    logic        to;
    lat       = 0;
    strobes   = 0;
    seen_addr = '0;
    d         = '0;
    mis       = 1'b0;
    to        = 1'b0;
    @(negedge clk);
    check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_funct3 = f3;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (mem_rd_en) begin
        strobes++;
        seen_addr = mem_addr;
      end
      if (rsp_valid) begin
        lat = k;
        d   = rsp_data;
        mis = rsp_misaligned;
        to  = rsp_timeout;
        break;
      end
    end
    check({tag, " data"}, d, exp_data);
    check({tag, " misaligned"}, {31'd0, mis}, {31'd0, exp_mis});
    check({tag, " timeout"}, {31'd0, to}, {31'd0, exp_to});
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " strobes"}, strobes, exp_strobes);
    if (exp_strobes > 0) check({tag, " mem_addr"}, seen_addr, addr & 32'hffff_fffc);
  endtask

  initial begin
    int stray;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[11] = 32'hdeadbeef;
    mem[12] = 32'h12345678;
    mem[13] = 32'h89abcdef;

    reset      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_funct3 = '0;
    repeat (3) @(negedge clk);
    check("rst req_ready", {31'd0, req_ready}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst flags", {30'd0, rsp_misaligned, rsp_timeout}, 32'd0);
    check("rst rsp_data", rsp_data, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    reset = 1'b1;

    mem_lat = 1;
    run_load("lw44", 32'd44, OpLw, 32'hdeadbeef, 1'b0, 1'b0, 3, 1);
    @(negedge clk);
    check("hold data", rsp_data, 32'hdeadbeef);
    check("hold rsp_valid", {31'd0, rsp_valid}, 32'd0);
    run_load("lb45", 32'd45, OpLb, 32'hffffffbe, 1'b0, 1'b0, 3, 1);
    run_load("lbu45", 32'd45, OpLbu, 32'h000000be, 1'b0, 1'b0, 3, 1);
    run_load("lhu46", 32'd46, OpLhu, 32'h0000dead, 1'b0, 1'b0, 3, 1);
    run_load("lh46", 32'd46, OpLh, 32'hffffdead, 1'b0, 1'b0, 3, 1);
    run_load("lb44", 32'd44, OpLb, 32'hffffffef, 1'b0, 1'b0, 3, 1);
    run_load("lh47", 32'd47, OpLh, 32'h0, 1'b1, 1'b0, 1, 0);
    run_load("lw46", 32'd46, OpLw, 32'h0, 1'b1, 1'b0, 1, 0);
    run_load("ill011", 32'd44, 3'b011, 32'h0, 1'b1, 1'b0, 1, 0);

    // Silent memory: 16 WAIT cycles after the ISSUE cycle, then RESP.
    mem_mute = 1'b1;
    run_load("tmo", 32'd44, OpLw, 32'h0, 1'b0, 1'b1, 18, 1);
    @(negedge clk);
    check("tmo ready after", {31'd0, req_ready}, 32'd1);
    mem_mute = 1'b0;

    // Reset in WAIT, memory answers later while idle.
    mem_lat = 5;
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = 32'd44;
    req_funct3 = OpLw;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rstw busy before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("rstw busy", {31'd0, busy}, 32'd0);
    check("rstw ready", {31'd0, req_ready}, 32'd1);
    check("rstw rsp_valid", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b1;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid || busy) stray++;
    end
    check("rstw late valid ignored", stray, 0);
    check("rstw rsp_data", rsp_data, 32'd0);

    mem_lat = 3;
    run_load("b2b lw48", 32'd48, OpLw, 32'h12345678, 1'b0, 1'b0, 5, 1);
    run_load("b2b lw52", 32'd52, OpLw, 32'h89abcdef, 1'b0, 1'b0, 5, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
